cartoon_stylizer: RTL and testbench
===================================

# cartoon_stylizer

Pipelined, parametrised cartoon-effect stage for the camera video path: it combines a blurred pixel, an edge-magnitude sample and the original pixel into a stylised output. It sits between the blur/edge filters and the display output and replaces the single-mode combinational cartoon stage. Channel width, posterize depth and edge thickening are configurable. Configuration is latched per frame, and a 2-cycle latency-matched side channel is provided.

## Interface

Parameters:
- DW, 8, bits per colour channel
- EW, 8, edge-magnitude width
- PW, 24, pass-through side-channel width
- QBITS, 3, posterize levels as retained MSBs per channel (1..DW; DW = no quantisation)
- THICK, 2, extra pixels an edge is extended to the right on a line (0 = off, max 15)
- EDGE_COLOR, {3*DW{1'b0}}, RGB drawn on edge pixels

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset, synchronous and active-high
- in_valid  in  1  pixel present this cycle
- in_sof  in  1  first pixel of frame (qualified by in_valid)
- in_sol  in  1  first pixel of line (qualified by in_valid)
- r, g, b  in  DW each  original pixel
- blur  in  3*DW  blurred pixel {R,G,B}
- edge  in  EW  edge magnitude
- en  in  1  effect enable (0 = bypass)
- mode  in  2  0 blur+edges, 1 posterized blur+edges, 2 edges-only, 3 posterized original
- threshold  in  EW  edge decision threshold
- pass_in  in  PW  side channel
- out_valid, out_sof, out_sol  out  1 each  delayed qualifiers
- outR, outG, outB  out  DW each  result
- pass_thru  out  PW  pass_in delayed to align with outR/G/B

## Operation

- **Config latch.** en, mode and threshold are captured into cfg registers only on a cycle with in_valid && in_sof. That pixel already uses the new values. They are held for the rest of the frame, so mid-frame changes are ignored. Reset values: en=0, mode=0, threshold=0.
- **Edge hit.** edge_hit = (edge > threshold), unsigned compare.
- **Thickening counter (run_cnt, 4 bits).** Advances only on valid pixels:
  - On in_sol or in_sof, the count is treated as 0 for that pixel before evaluation.
  - If edge_hit: run_cnt ← THICK.
  - Else if run_cnt ≠ 0: decrement.
  - edge_eff = edge_hit || (effective run_cnt ≠ 0).
  - Invalid cycles leave run_cnt unchanged.
- **Posterize P(x).** Replicate the top QBITS bits of x, MSB first, until DW bits are filled. Example: DW=8, QBITS=3, 0xB7 → 0xB6. QBITS=DW gives identity.
- **Output selection** when cfg_en=1 (when cfg_en=0, output = {r,g,b}):
  - mode 0: edge_eff ? EDGE_COLOR : blur
  - mode 1: edge_eff ? EDGE_COLOR : P(blur) per channel
  - mode 2: edge_eff ? EDGE_COLOR : all-ones
  - mode 3: P({r,g,b}), with edges ignored
- **Reset values.** All outputs, pipeline registers, run_cnt and cfg are 0 on reset.
- **Reset mid-frame.** The pipeline is flushed: out_valid=0 on the next cycle, and cfg returns to defaults until the next in_sof.

## Timing

- Fixed latency of 2 cycles from an input sample to outR/G/B, out_*, pass_thru. There is no backpressure; bubbles (in_valid=0) propagate as out_valid=0.
- Stage 1 registers cfg-resolved selection inputs, edge_eff and qualifiers. Stage 2 registers the posterize/mux result.
- Data and pass_thru registers load every cycle regardless of in_valid. out_valid is the only qualifier.
- Config captured on an sof pixel at cycle N affects the output at cycle N+2.
- Simultaneous in_sof and in_sol: both act. The counter is cleared and config is latched.
- Throughput: one pixel per clock.

## Test plan

- **Reset.** Hold rst 2 cycles with random inputs → outR/G/B=0, pass_thru=0, out_valid=0. After release, the first in_valid pixel appears 2 cycles later.
- **Mode 0, threshold 0.** Frame start with blur=0x336699, edge=0x00 → out 0x33/0x66/0x99 at N+2. Next pixel with edge=0x01 → 0x00/0x00/0x00.
- **Frame latch.** Mid-frame, change threshold to 0x80 and mode to 2; feed edge=0x40 → still EDGE_COLOR (old threshold 0, mode 0). After the next in_sof, edge=0x40 → 0xFF/0xFF/0xFF (mode 2 background).
- **Thickening, THICK=2.**
  - edge sequence 0xFF,0,0,0 → EDGE,EDGE,EDGE,blur.
  - Repeat with in_sol on the 2nd pixel → EDGE,blur,blur,blur.
  - An invalid gap inside the run does not consume the count.
- **Posterize, mode 1, QBITS=3.** blur=0xB71F80 → 0xB6/0x00/0x92. Mode 3 on r,g,b=0xFF,0x20,0x7F → 0xFF/0x24/0x6D.
- **Bypass and reset.** With en=0 latched, outputs equal {r,g,b} and pass_in delayed exactly 2 cycles, bubbles preserved. Assert rst mid-line → out_valid=0 next cycle, and cfg_en=0 until the next sof.

Source files
------------

// File: rtl/cartoon_stylizer.sv
// Two-stage cartoon-effect pixel stage: frame-latched config, edge thickening along
// each line, posterize and output-mode mux, with a latency-matched side channel.
module cartoon_stylizer #(
  parameter int              DW         = 8,
  parameter int              EW         = 8,
  parameter int              PW         = 24,
  parameter int              QBITS      = 3,
  parameter int              THICK      = 2,
  parameter logic [3*DW-1:0] EDGE_COLOR = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            in_sof,
  input  logic            in_sol,
  input  logic [DW-1:0]   r,
  input  logic [DW-1:0]   g,
  input  logic [DW-1:0]   b,
  input  logic [3*DW-1:0] blur,
  input  logic [EW-1:0]   edge_mag,
  input  logic            en,
  input  logic [1:0]      mode,
  input  logic [EW-1:0]   threshold,
  input  logic [PW-1:0]   pass_in,
  output logic            out_valid,
  output logic            out_sof,
  output logic            out_sol,
  output logic [DW-1:0]   outR,
  output logic [DW-1:0]   outG,
  output logic [DW-1:0]   outB,
  output logic [PW-1:0]   pass_thru
);

  localparam int CW = 3 * DW;

  // Replicate the retained MSBs downward so full-scale stays full-scale.
  function automatic logic [DW-1:0] posterize(input logic [DW-1:0] x);
    logic [DW-1:0] y;
    y = '0;
    for (int i = 0; i < DW; i++) begin
      y[DW-1-i] = x[DW-1-(i % QBITS)];
    end
    return y;
  endfunction

  logic          cfg_en_reg, cfg_en_next;
  logic [1:0]    cfg_mode_reg, cfg_mode_next;
  logic [EW-1:0] cfg_thr_reg, cfg_thr_next;
  logic [3:0]    run_cnt_reg, run_cnt_next;
  logic [3:0]    run_eff;
  logic          edge_hit, edge_eff;

  // The sof pixel itself already uses the freshly latched configuration.
  always_comb begin
    cfg_en_next   = cfg_en_reg;
    cfg_mode_next = cfg_mode_reg;
    cfg_thr_next  = cfg_thr_reg;
    if (in_valid && in_sof) begin
      cfg_en_next   = en;
      cfg_mode_next = mode;
      cfg_thr_next  = threshold;
    end
  end

  always_comb begin
    run_eff      = (in_sof || in_sol) ? 4'd0 : run_cnt_reg;
    edge_hit     = edge_mag > cfg_thr_next;
    edge_eff     = edge_hit || (run_eff != 4'd0);
    run_cnt_next = run_cnt_reg;
    if (in_valid) begin
      if (edge_hit)
        run_cnt_next = 4'(THICK);
      else if (run_eff != 4'd0)
        run_cnt_next = run_eff - 4'd1;
      else
        run_cnt_next = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_en_reg   <= 1'b0;
      cfg_mode_reg <= 2'd0;
      cfg_thr_reg  <= '0;
      run_cnt_reg  <= 4'd0;
    end else begin
      cfg_en_reg   <= cfg_en_next;
      cfg_mode_reg <= cfg_mode_next;
      cfg_thr_reg  <= cfg_thr_next;
      run_cnt_reg  <= run_cnt_next;
    end
  end

  logic          s1_valid, s1_sof, s1_sol, s1_en, s1_edge;
  logic [1:0]    s1_mode;
  logic [CW-1:0] s1_rgb, s1_blur;
  logic [PW-1:0] s1_pass;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sof   <= 1'b0;
      s1_sol   <= 1'b0;
      s1_en    <= 1'b0;
      s1_edge  <= 1'b0;
      s1_mode  <= 2'd0;
      s1_rgb   <= '0;
      s1_blur  <= '0;
      s1_pass  <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_sof   <= in_valid && in_sof;
      s1_sol   <= in_valid && in_sol;
      s1_en    <= cfg_en_next;
      s1_edge  <= edge_eff;
      s1_mode  <= cfg_mode_next;
      s1_rgb   <= {r, g, b};
      s1_blur  <= blur;
      s1_pass  <= pass_in;
    end
  end

  logic [CW-1:0] blur_post, rgb_post, result;

  for (genvar gi = 0; gi < 3; gi++) begin : g_post
    assign blur_post[gi*DW +: DW] = posterize(s1_blur[gi*DW +: DW]);
    assign rgb_post[gi*DW +: DW]  = posterize(s1_rgb[gi*DW +: DW]);
  end

  always_comb begin
    result = s1_rgb;
    if (s1_en) begin
      case (s1_mode)
        2'd0:    result = s1_edge ? EDGE_COLOR : s1_blur;
        2'd1:    result = s1_edge ? EDGE_COLOR : blur_post;
        2'd2:    result = s1_edge ? EDGE_COLOR : {CW{1'b1}};
        default: result = rgb_post;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_sol   <= 1'b0;
      outR      <= '0;
      outG      <= '0;
      outB      <= '0;
      pass_thru <= '0;
    end else begin
      out_valid <= s1_valid;
      out_sof   <= s1_sof;
      out_sol   <= s1_sol;
      {outR, outG, outB} <= result;
      pass_thru <= s1_pass;
    end
  end

endmodule

// File: tb/tb_cartoon_stylizer.sv
// Scoreboard bench for cartoon_stylizer: directed scenarios then random traffic,
// checked against a distance-since-last-edge reference model.
module tb_cartoon_stylizer;

  localparam int INF   = 1000;
  localparam int THICK = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_sof = 1'b0, in_sol = 1'b0;
  logic [7:0]  r = '0, g = '0, b = '0;
  logic [23:0] blur = '0;
  logic [7:0]  edge_mag = '0;
  logic        en = 1'b0;
  logic [1:0]  mode = '0;
  logic [7:0]  threshold = '0;
  logic [23:0] pass_in = '0;
  logic        out_valid, out_sof, out_sol;
  logic [7:0]  outR, outG, outB;
  logic [23:0] pass_thru;

  cartoon_stylizer #(
    .DW(8), .EW(8), .PW(24), .QBITS(3), .THICK(THICK), .EDGE_COLOR(24'h000000)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_sol(in_sol),
    .r(r), .g(g), .b(b), .blur(blur), .edge_mag(edge_mag), .en(en), .mode(mode),
    .threshold(threshold), .pass_in(pass_in), .out_valid(out_valid),
    .out_sof(out_sof), .out_sol(out_sol), .outR(outR), .outG(outG), .outB(outB),
    .pass_thru(pass_thru)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          issue;
    logic        sof;
    logic        sol;
    logic [23:0] rgb;
    logic [23:0] pass;
    bit          has_c;
    logic [23:0] cval;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model state: frame config and pixels elapsed since last edge hit on this line.
  logic       m_en = 1'b0;
  logic [1:0] m_mode = 2'd0;
  logic [7:0] m_thr = 8'd0;
  int         m_dist = INF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic logic [7:0] post8(input logic [7:0] x);
    int q, acc, n;
    q = int'(x) >> 5;
    acc = 0;
    n = 0;
    while (n < 8) begin
      acc = (acc << 3) | q;
      n += 3;
    end
    return 8'(acc >> (n - 8));
  endfunction

  function automatic logic [23:0] post24(input logic [23:0] x);
    return {post8(x[23:16]), post8(x[15:8]), post8(x[7:0])};
  endfunction

  function automatic logic [23:0] model_pixel(input logic [23:0] rgb, input logic [23:0] bl,
                                              input logic eff);
    if (!m_en) return rgb;
    case (m_mode)
      2'd0:    return eff ? 24'h000000 : bl;
      2'd1:    return eff ? 24'h000000 : post24(bl);
      2'd2:    return eff ? 24'h000000 : 24'hFFFFFF;
      default: return post24(rgb);
    endcase
  endfunction

  task automatic drive(input logic v, input logic sof, input logic sol, input logic [23:0] rgb,
                       input logic [23:0] bl, input logic [7:0] e, input logic c_en,
                       input logic [1:0] c_mode, input logic [7:0] c_thr,
                       input bit has_c, input logic [23:0] cval);
    exp_t x;
    logic eff;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = v; in_sof = sof; in_sol = sol;
    {r, g, b} = rgb; blur = bl; edge_mag = e;
    en = c_en; mode = c_mode; threshold = c_thr;
    pass_in = 24'($urandom);
    if (v) begin
      if (sof) begin
        m_en = c_en; m_mode = c_mode; m_thr = c_thr;
      end
      if (sof || sol) m_dist = INF;
      if (e > m_thr) m_dist = 0;
      else if (m_dist < INF) m_dist++;
      eff = (m_dist <= THICK);
      x.issue = cyc; x.sof = sof; x.sol = sol;
      x.rgb = model_pixel(rgb, bl, eff);
      x.pass = pass_in; x.has_c = has_c; x.cval = cval;
      sb.push_back(x);
    end
  endtask

  task automatic randomize_inputs();
    in_valid = 1'($urandom); in_sof = 1'($urandom); in_sol = 1'($urandom);
    {r, g, b} = 24'($urandom); blur = 24'($urandom); edge_mag = 8'($urandom);
    en = 1'($urandom); mode = 2'($urandom); threshold = 8'($urandom);
    pass_in = 24'($urandom);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    while (sb.size() > 0 && sb[$].issue >= cyc - 1) void'(sb.pop_back());
    rst = 1'b1;
    randomize_inputs();
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_rgb", {8'd0, outR, outG, outB}, 32'd0);
      chk("rst_pass_thru", {8'd0, pass_thru}, 32'd0);
      if (i < n) randomize_inputs();
      else begin
        rst = 1'b0;
        in_valid = 1'b0;
      end
    end
    m_en = 1'b0; m_mode = 2'd0; m_thr = 8'd0; m_dist = INF;
  endtask

  // Monitor: pops on every presented output and flags dropped or spurious pixels.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("latency", cyc - e.issue, 32'd2);
          chk("pixel", {8'd0, outR, outG, outB}, {8'd0, e.rgb});
          chk("pass_thru", {8'd0, pass_thru}, {8'd0, e.pass});
          chk("sof_sol", {30'd0, out_sof, out_sol}, {30'd0, e.sof, e.sol});
          if (e.has_c) chk("pixel_const", {8'd0, outR, outG, outB}, {8'd0, e.cval});
        end
      end else if (sb.size() > 0 && cyc - sb[0].issue >= 2) begin
        chk("missing_output", 32'd0, 32'd1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    logic [23:0] px;
    logic        v, sof, sol;
    do_reset(2);

    // Mode 0, threshold 0, then mid-frame config change is ignored.
    drive(1, 1, 1, 24'h010203, 24'h336699, 8'h00, 1, 2'd0, 8'h00, 1, 24'h336699);
    drive(1, 0, 0, 24'h010203, 24'h336699, 8'h01, 1, 2'd0, 8'h00, 1, 24'h000000);
    drive(1, 0, 0, 24'h010203, 24'h336699, 8'h40, 1, 2'd2, 8'h80, 1, 24'h000000);
    drive(1, 1, 1, 24'h010203, 24'h336699, 8'h40, 1, 2'd2, 8'h80, 1, 24'hFFFFFF);

    // Thickening: plain run, run cut by a new line, run across an invalid gap.
    drive(1, 1, 1, 24'h0, 24'h123456, 8'hFF, 1, 2'd0, 8'h00, 1, 24'h000000);
    drive(1, 0, 0, 24'h0, 24'h123456, 8'h00, 1, 2'd0, 8'h00, 1, 24'h000000);
    drive(1, 0, 0, 24'h0, 24'h123456, 8'h00, 1, 2'd0, 8'h00, 1, 24'h000000);
    drive(1, 0, 0, 24'h0, 24'h123456, 8'h00, 1, 2'd0, 8'h00, 1, 24'h123456);
    drive(1, 0, 1, 24'h0, 24'h123456, 8'hFF, 1, 2'd0, 8'h00, 1, 24'h000000);
    drive(1, 0, 1, 24'h0, 24'h123456, 8'h00, 1, 2'd0, 8'h00, 1, 24'h123456);
    drive(1, 0, 0, 24'h0, 24'h123456, 8'h00, 1, 2'd0, 8'h00, 1, 24'h123456);
    drive(1, 0, 0, 24'h0, 24'h123456, 8'h00, 1, 2'd0, 8'h00, 1, 24'h123456);
    drive(1, 0, 1, 24'h0, 24'h123456, 8'hFF, 1, 2'd0, 8'h00, 1, 24'h000000);
    drive(1, 0, 0, 24'h0, 24'h123456, 8'h00, 1, 2'd0, 8'h00, 1, 24'h000000);
    drive(0, 0, 0, 24'h0, 24'h123456, 8'h00, 1, 2'd0, 8'h00, 0, 24'h0);
    drive(0, 0, 0, 24'h0, 24'h123456, 8'hFF, 1, 2'd0, 8'h00, 0, 24'h0);
    drive(1, 0, 0, 24'h0, 24'h123456, 8'h00, 1, 2'd0, 8'h00, 1, 24'h000000);
    drive(1, 0, 0, 24'h0, 24'h123456, 8'h00, 1, 2'd0, 8'h00, 1, 24'h123456);

    // Posterize in mode 1 and mode 3.
    drive(1, 1, 1, 24'h0, 24'hB71F80, 8'h00, 1, 2'd1, 8'h00, 1, 24'hB60092);
    drive(1, 1, 1, 24'hFF207F, 24'h0, 8'hFF, 1, 2'd3, 8'h00, 1, 24'hFF246D);

    // Bypass with bubbles.
    drive(1, 1, 1, 24'hA1B2C3, 24'h0, 8'hFF, 0, 2'd2, 8'h00, 1, 24'hA1B2C3);
    drive(0, 0, 0, 24'h0, 24'h0, 8'h00, 1, 2'd0, 8'h00, 0, 24'h0);
    drive(1, 0, 0, 24'h445566, 24'h0, 8'hFF, 1, 2'd2, 8'h00, 1, 24'h445566);

    // Reset mid-line: afterwards cfg_en stays 0 until the next sof.
    drive(1, 1, 1, 24'h0, 24'h777777, 8'h00, 1, 2'd0, 8'h00, 1, 24'h777777);
    drive(1, 0, 0, 24'h0, 24'h777777, 8'h00, 1, 2'd0, 8'h00, 0, 24'h0);
    do_reset(1);
    drive(1, 0, 0, 24'h9A8B7C, 24'h0, 8'hFF, 1, 2'd2, 8'h00, 1, 24'h9A8B7C);
    drive(1, 0, 1, 24'h135790, 24'h0, 8'h00, 1, 2'd2, 8'h00, 1, 24'h135790);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset($urandom_range(1, 2));
      end else begin
        v   = ($urandom_range(0, 3) != 0);
        sof = ($urandom_range(0, 29) == 0);
        sol = sof || ($urandom_range(0, 9) == 0);
        px  = 24'($urandom);
        drive(v, sof, sol, px, 24'($urandom),
              ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 31)),
              ($urandom_range(0, 3) != 0), 2'($urandom), 8'($urandom_range(0, 63)), 0, 24'h0);
      end
    end

    drive(0, 0, 0, 24'h0, 24'h0, 8'h00, 0, 2'd0, 8'h00, 0, 24'h0);
    repeat (4) @(posedge clk);
    #3;
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
